// File: rtl/fir_post_pkg.sv
// Shared constants and FIFO entry layout for the FIR output packer.
package fir_post_pkg;

    localparam int IN_WIDTH_DEF  = 20;
    localparam int OUT_WIDTH_DEF = 8;

    localparam logic signed [OUT_WIDTH_DEF-1:0] SAT_MAX = 8'sd127;
    localparam logic signed [OUT_WIDTH_DEF-1:0] SAT_MIN = -8'sd128;

    localparam logic CH_FIRST  = 1'b0;
    localparam logic CH_SECOND = 1'b1;

    // FIFO entry: channel tag in the MSB above the sample.
    typedef struct packed {
        logic                            channel;
        logic signed [OUT_WIDTH_DEF-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic right shift and saturate one filter result.
module fir_round_sat #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 6
) (
    input  logic signed [IN_WIDTH-1:0]  x,
    output logic signed [OUT_WIDTH-1:0] y,
    output logic                        clamp
);

    localparam logic signed [IN_WIDTH:0] HI = (IN_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [IN_WIDTH:0] LO = (IN_WIDTH+1)'(-(2**(OUT_WIDTH-1)));

    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] r;

    assign ext = {x[IN_WIDTH-1], x};

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    generate
        if (SHIFT == 0) begin : g_noshift
            assign r = ext;
        end else begin : g_shift
            localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(2**(SHIFT-1));
            logic signed [IN_WIDTH:0] sum;
            assign sum = ext + HALF;
            assign r   = sum >>> SHIFT;
        end
    endgenerate

    always_comb begin
        clamp = 1'b0;
        y     = r[OUT_WIDTH-1:0];
        if (r > HI) begin
            clamp = 1'b1;
            y     = HI[OUT_WIDTH-1:0];
        end else if (r < LO) begin
            clamp = 1'b1;
            y     = LO[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fir_dual_output_packer.sv
// Packs both FIR channels into 8-bit samples and interleaves them through a
// show-ahead FIFO with a valid/ready output and a channel tag.
module fir_dual_output_packer
    import fir_post_pkg::*;
#(
    parameter int IN_WIDTH   = IN_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int SHIFT      = 6,
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic signed [IN_WIDTH-1:0]    first_output_result,
    input  logic signed [IN_WIDTH-1:0]    second_output_result,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          out_channel,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    overflow_count,
    output logic                          sat_flag
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int ENT_W = OUT_WIDTH + 1;

    logic signed [IN_WIDTH-1:0]  in_res [2];
    logic signed [OUT_WIDTH-1:0] rs_data [2];
    logic [1:0]                  rs_clamp;

    logic [DEC_W-1:0]            dec_cnt_reg;
    logic                        accept;

    logic                        s1_valid_reg;
    logic signed [OUT_WIDTH-1:0] s1_data_reg [2];
    logic                        sat_flag_reg;

    logic [ENT_W-1:0]            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_reg;
    logic [PTR_W-1:0]            wr_ptr_inc;
    logic [PTR_W-1:0]            rd_ptr_reg;
    logic [LVL_W-1:0]            level_reg;
    logic [LVL_W-1:0]            level_next;
    logic [7:0]                  overflow_count_reg;
    logic [ENT_W-1:0]            head;
    logic                        push_ok;
    logic                        pop;

    assign in_res[0] = first_output_result;
    assign in_res[1] = second_output_result;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            fir_round_sat #(
                .IN_WIDTH  (IN_WIDTH),
                .OUT_WIDTH (OUT_WIDTH),
                .SHIFT     (SHIFT)
            ) u_round_sat (
                .x     (in_res[gi]),
                .y     (rs_data[gi]),
                .clamp (rs_clamp[gi])
            );
        end
    endgenerate

    assign accept = in_valid && (dec_cnt_reg == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt_reg <= '0;
        end else if (in_valid) begin
            dec_cnt_reg <= (dec_cnt_reg == DEC_W'(DECIM - 1)) ? '0 : dec_cnt_reg + DEC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            sat_flag_reg <= 1'b0;
            for (int i = 0; i < 2; i++) s1_data_reg[i] <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                for (int i = 0; i < 2; i++) s1_data_reg[i] <= rs_data[i];
                if (|rs_clamp) sat_flag_reg <= 1'b1;
            end
        end
    end

    // Free space is judged before the same-cycle pop, so a pair needs two slots.
    assign push_ok    = s1_valid_reg && (level_reg <= LVL_W'(FIFO_DEPTH - 2));
    assign pop        = (level_reg != '0) && out_ready;
    assign wr_ptr_inc = wr_ptr_reg + PTR_W'(1);
    assign level_next = level_reg + (push_ok ? LVL_W'(2) : LVL_W'(0)) - (pop ? LVL_W'(1) : LVL_W'(0));

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= {CH_FIRST, s1_data_reg[0]};
            mem[wr_ptr_inc] <= {CH_SECOND, s1_data_reg[1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            level_reg          <= '0;
            overflow_count_reg <= '0;
        end else begin
            level_reg <= level_next;
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(2);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (s1_valid_reg && !push_ok && (overflow_count_reg != 8'hFF))
                overflow_count_reg <= overflow_count_reg + 8'd1;
        end
    end

    // Gate the head so outputs read zero whenever the FIFO is empty.
    assign head           = mem[rd_ptr_reg];
    assign out_valid      = (level_reg != '0);
    assign out_data       = out_valid ? head[OUT_WIDTH-1:0] : '0;
    assign out_channel    = out_valid ? head[OUT_WIDTH] : 1'b0;
    assign fifo_level     = level_reg;
    assign overflow_count = overflow_count_reg;
    assign sat_flag       = sat_flag_reg;

endmodule

// File: tb/tb_fir_dual_output_packer.sv
// Directed self-checking bench for fir_dual_output_packer.
module tb_fir_dual_output_packer;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [19:0] first_output_result;
    logic signed [19:0] second_output_result;
    logic               out_ready;

    logic               out_valid, out_channel, sat_flag;
    logic signed [7:0]  out_data;
    logic [3:0]         fifo_level;
    logic [7:0]         overflow_count;

    logic               d_out_valid, d_out_channel, d_sat_flag;
    logic signed [7:0]  d_out_data;
    logic [3:0]         d_fifo_level;
    logic [7:0]         d_overflow_count;

    int checks = 0;
    int errors = 0;
    logic [8:0] q  [$];
    logic [8:0] q2 [$];

    always #5 clk = ~clk;

    fir_dual_output_packer #(
        .IN_WIDTH(20), .OUT_WIDTH(8), .SHIFT(6), .DECIM(1), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .first_output_result(first_output_result),
        .second_output_result(second_output_result),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_channel(out_channel), .fifo_level(fifo_level),
        .overflow_count(overflow_count), .sat_flag(sat_flag)
    );

    fir_dual_output_packer #(
        .IN_WIDTH(20), .OUT_WIDTH(8), .SHIFT(6), .DECIM(3), .FIFO_DEPTH(8)
    ) dut_dec (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .first_output_result(first_output_result),
        .second_output_result(second_output_result),
        .out_ready(out_ready), .out_valid(d_out_valid), .out_data(d_out_data),
        .out_channel(d_out_channel), .fifo_level(d_fifo_level),
        .overflow_count(d_overflow_count), .sat_flag(d_sat_flag)
    );

    // Record every accepted output sample; inputs only change just after posedge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            q.push_back({out_channel, out_data});
            $display("[%0t] dut     out ch=%0d data=%0d", $time, out_channel, out_data);
        end
        if (!reset && d_out_valid && out_ready) begin
            q2.push_back({d_out_channel, d_out_data});
            $display("[%0t] dut_dec out ch=%0d data=%0d", $time, d_out_channel, d_out_data);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int ch, input int val);
        logic [8:0] e;
        check({tag, "_avail"}, int'(q.size() > 0), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check({tag, "_ch"}, int'(e[8]), ch);
            check({tag, "_data"}, int'($signed(e[7:0])), val);
        end
    endtask

    task automatic expect_dec(input string tag, input int ch, input int val);
        logic [8:0] e;
        check({tag, "_avail"}, int'(q2.size() > 0), 1);
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check({tag, "_ch"}, int'(e[8]), ch);
            check({tag, "_data"}, int'($signed(e[7:0])), val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input int a, input int b);
        in_valid             = 1'b1;
        first_output_result  = 20'(a);
        second_output_result = 20'(b);
        step(1);
        in_valid             = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        q.delete();
        q2.delete();
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        first_output_result = '0;
        second_output_result = '0;
        out_ready = 1'b0;
        step(2);
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_ch", int'(out_channel), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ovf", int'(overflow_count), 0);
        check("rst_sat", int'(sat_flag), 0);
        reset = 1'b0;

        // Rounding
        out_ready = 1'b1;
        drive_pair(96, -96);
        drive_pair(95, 64);
        step(8);
        expect_out("t1_s0", 0, 2);
        expect_out("t1_s1", 1, -1);
        expect_out("t1_s2", 0, 1);
        expect_out("t1_s3", 1, 1);
        check("t1_sat", int'(sat_flag), 0);

        // Saturation, sticky flag
        drive_pair(10000, -20000);
        step(6);
        expect_out("t2_s0", 0, 127);
        expect_out("t2_s1", 1, -128);
        check("t2_sat", int'(sat_flag), 1);
        step(20);
        check("t2_sat_hold", int'(sat_flag), 1);

        // Backpressure and overflow
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) drive_pair(64 * k, -64 * k);
        step(2);
        check("t3_level", int'(fifo_level), 8);
        check("t3_ovf", int'(overflow_count), 1);
        check("t3_head", int'(out_data), 1);
        check("t3_head_ch", int'(out_channel), 0);
        step(3);
        check("t3_head_hold", int'(out_data), 1);
        q.delete();
        out_ready = 1'b1;
        step(14);
        check("t3_count", q.size(), 8);
        for (int k = 1; k <= 4; k++) begin
            expect_out($sformatf("t3_p%0d_c0", k), 0, k);
            expect_out($sformatf("t3_p%0d_c1", k), 1, -k);
        end
        check("t3_level_end", int'(fifo_level), 0);

        // Decimation by 3 on the second instance
        do_reset();
        for (int k = 0; k < 6; k++) drive_pair(64 * (k + 10), -64 * (k + 10));
        step(10);
        check("t4_count", q2.size(), 4);
        expect_dec("t4_p0_c0", 0, 10);
        expect_dec("t4_p0_c1", 1, -10);
        expect_dec("t4_p3_c0", 0, 13);
        expect_dec("t4_p3_c1", 1, -13);

        // Latency
        do_reset();
        drive_pair(320, -320);
        check("t5_n0_valid", int'(out_valid), 0);
        step(1);
        check("t5_n1_valid", int'(out_valid), 1);
        check("t5_n1_ch", int'(out_channel), 0);
        check("t5_n1_data", int'(out_data), 5);
        step(1);
        check("t5_n2_valid", int'(out_valid), 1);
        check("t5_n2_ch", int'(out_channel), 1);
        check("t5_n2_data", int'(out_data), -5);
        step(1);
        check("t5_n3_valid", int'(out_valid), 0);

        // Asynchronous reset mid-cycle
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) drive_pair(100000, -100000);
        step(2);
        check("t6_pre_level", int'(fifo_level), 6);
        check("t6_pre_sat", int'(sat_flag), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_valid", int'(out_valid), 0);
        check("t6_async_level", int'(fifo_level), 0);
        check("t6_async_ovf", int'(overflow_count), 0);
        check("t6_async_sat", int'(sat_flag), 0);
        step(1);
        reset = 1'b0;
        q.delete();
        out_ready = 1'b1;
        drive_pair(128, -128);
        step(6);
        expect_out("t6_resume_c0", 0, 2);
        expect_out("t6_resume_c1", 1, -2);
        check("t6_resume_sat", int'(sat_flag), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
